button_conditioner: RTL

- Multi-channel successor to the single-button debouncer. It synchronises, debounces and edge-detects N raw pushbutton/switch inputs in one block.
- Per channel it provides a clean level, one-cycle press and release pulses, and an optional hold-to-repeat press stream.
- Sits between the board buttons (btnc/btnl/btnr/btnu/btnd, switches) and the player-control / game-state logic in top_level.

---
 rtl/button_conditioner_pkg.sv | 30 +++
 rtl/button_conditioner_if.sv | 35 +++
 rtl/button_conditioner_debounce_channel.sv | 117 +++++++++++
 rtl/button_conditioner.sv | 53 +++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the player-input path: channel indices and debounce defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: BTN_* channel indices, NUM_BUTTONS, DEBOUNCE_CYCLES_DEFAULT,
//           repeat_phase_t (auto-repeat phase) and max_int helper.
package overcooked_input_pkg;

  // Channel index of each board button within the conditioned bus.
  localparam int BTN_CHOP  = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 4;

  localparam int NUM_BUTTONS = 5;

  // About 15.4 ms of required stability at the 65 MHz pixel clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  // Auto-repeat: waiting for the initial hold delay, then the steady period.
  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } repeat_phase_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus between the raw board inputs and the player-control logic.
// Latency: n/a (wiring only).
// Backpressure: none; levels and pulses are unconditional.
// Signals: noisy_in (raw levels), clean_out (debounced levels),
//          rise_out / fall_out (one-cycle edge pulses), press_out (rise plus repeats).
// Modports: slave = conditioner side, master = source/consumer side.
interface button_conditioner_if
  import overcooked_input_pkg::*;
#(
  parameter int NUM_CH = NUM_BUTTONS
) ();

  logic [NUM_CH-1:0] noisy_in;
  logic [NUM_CH-1:0] clean_out;
  logic [NUM_CH-1:0] rise_out;
  logic [NUM_CH-1:0] fall_out;
  logic [NUM_CH-1:0] press_out;

  modport slave (
    input  noisy_in,
    output clean_out,
    output rise_out,
    output fall_out,
    output press_out
  );

  modport master (
    output noisy_in,
    input  clean_out,
    input  rise_out,
    input  fall_out,
    input  press_out
  );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, edge pulses, optional auto-repeat.
// Latency: a stable input change reaches clean on the (DEBOUNCE_CYCLES+4)th clock_in edge.
// Backpressure: none; pulses are single-cycle and unconditional.
// Ports: clock_in, reset_in (sync, active-high), noisy (raw level),
//        clean, rise, fall, press (registered outputs).
// Build option: BUTTON_CONDITIONER_AUTOREPEAT_EN adds the hold-to-repeat press stream.
module debounce_channel
  import overcooked_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 26_000_000,
  parameter int REPEAT_PERIOD = 6_500_000
`endif
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          candidate;
  logic [CW-1:0] cnt;

  // The counter saturates at CNT_MAX, so commit stays true while the input is
  // stable; the edge terms only fire when the committed value actually differs.
  logic commit;
  logic commit_rise;
  logic commit_fall;

  assign commit      = (sync2 == candidate) && (cnt == CNT_MAX);
  assign commit_rise = commit &&  candidate && !clean;
  assign commit_fall = commit && !candidate &&  clean;

  // Reset captures the live input everywhere so no edge is reported for it.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      sync1     <= noisy;
      sync2     <= noisy;
      candidate <= noisy;
      clean     <= noisy;
      cnt       <= '0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync1 <= noisy;
      sync2 <= sync1;
      rise  <= commit_rise;
      fall  <= commit_fall;
      if (sync2 != candidate) begin
        candidate <= sync2;
        cnt       <= '0;
      end else if (cnt == CNT_MAX) begin
        clean <= candidate;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] DELAY_END  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_END = RW'(REPEAT_PERIOD - 1);

  repeat_phase_t phase, phase_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic          rep, rep_nxt;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      phase <= PH_DELAY;
      rcnt  <= '0;
      rep   <= 1'b0;
    end else begin
      phase <= phase_nxt;
      rcnt  <= rcnt_nxt;
      rep   <= rep_nxt;
    end
  end

  // A falling commit clears the counter on the same edge, so a release can
  // never be followed by a stray repeat pulse.
  always_comb begin
    phase_nxt = phase;
    rcnt_nxt  = rcnt;
    rep_nxt   = 1'b0;
    if (commit_rise || !clean || commit_fall) begin
      rcnt_nxt  = '0;
      phase_nxt = PH_DELAY;
    end else if ((phase == PH_DELAY) && (rcnt == DELAY_END)) begin
      rep_nxt   = 1'b1;
      rcnt_nxt  = '0;
      phase_nxt = PH_PERIOD;
    end else if ((phase == PH_PERIOD) && (rcnt == PERIOD_END)) begin
      rep_nxt  = 1'b1;
      rcnt_nxt = '0;
    end else begin
      rcnt_nxt = rcnt + RW'(1);
    end
  end

  assign press = rise | rep;
`else
  assign press = rise;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: NUM_CH independent synchronise/debounce/edge-detect lanes.
// Latency: a stable input change reaches clean_out on the (DEBOUNCE_CYCLES+4)th clock_in edge.
// Backpressure: none; every lane outputs unconditional levels and one-cycle pulses.
// Ports: clock_in, reset_in (sync, active-high), btn (button_conditioner_if.slave:
//        noisy_in in; clean_out, rise_out, fall_out, press_out out).
// Build option: BUTTON_CONDITIONER_AUTOREPEAT_EN enables hold-to-repeat on press_out.
module button_conditioner
  import overcooked_input_pkg::*;
#(
  parameter int NUM_CH          = NUM_BUTTONS,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = 26_000_000,
  parameter int REPEAT_PERIOD   = 6_500_000
) (
  input  logic           clock_in,
  input  logic           reset_in,
  button_conditioner_if.slave btn
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [NUM_CH-1:0] clean_v;
  logic [NUM_CH-1:0] rise_v;
  logic [NUM_CH-1:0] fall_v;
  logic [NUM_CH-1:0] press_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clock_in(clock_in),
      .reset_in(reset_in),
      .noisy   (btn.noisy_in[i]),
      .clean   (clean_v[i]),
      .rise    (rise_v[i]),
      .fall    (fall_v[i]),
      .press   (press_v[i])
    );
  end

  assign btn.clean_out = clean_v;
  assign btn.rise_out  = rise_v;
  assign btn.fall_out  = fall_v;
  assign btn.press_out = press_v;

endmodule
